// File: rtl/tlp_xcvr_pkg.sv
// Shared types and sizing for the TLP transceiver: chunk geometry, the
// F2C arbiter state encoding and the plain word typedefs.
package tlp_xcvr_pkg;

  typedef logic [63:0] uint64;
  typedef logic [31:0] uint32;

  // F2C chunk size in bytes; the arbiter counts in 64-bit quadwords.
  localparam int F2C_CHUNKSIZE = 1024;
  localparam int CHUNK_QWS_DEF = F2C_CHUNKSIZE / 8;

  typedef enum logic {
    S_IDLE,
    S_XFER
  } arbState_t;

endpackage

// File: rtl/f2c_chunk_arb_rr_pick.sv
// Combinational round-robin selector: first set request bit found searching
// upward from rrPtr, wrapping modulo NUM_SRC (non-power-of-two safe).
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   rrPtr,
  output logic [PTR_W-1:0]   winner,
  output logic               anyReq
);

  int idx;

  always_comb begin
    winner = '0;
    anyReq = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rrPtr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!anyReq && req[PTR_W'(idx)]) begin
        anyReq = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/f2c_chunk_arb.sv
// Round-robin chunk scheduler in front of the F2C DMA pipe: one source owns
// the pipe for a whole chunk. Optional statistics ports under F2C_ARB_STATS_EN.
module f2c_chunk_arb
  import tlp_xcvr_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int CHUNK_QWS = CHUNK_QWS_DEF,
  parameter int PTR_W     = $clog2(NUM_SRC),
  parameter int QW_W      = (CHUNK_QWS > 1) ? $clog2(CHUNK_QWS) : 1
) (
  input  logic                  pcieClk_in,
  input  logic                  pcieRst_in,
  input  logic [NUM_SRC*64-1:0] srcData_in,
  input  logic [NUM_SRC-1:0]    srcValid_in,
  input  logic [NUM_SRC-1:0]    srcChunkRdy_in,
  input  logic [NUM_SRC-1:0]    srcEnable_in,
  output logic [NUM_SRC-1:0]    srcReady_out,
  output logic [NUM_SRC-1:0]    srcReset_out,
  output logic [63:0]           f2cData_out,
  output logic                  f2cValid_out,
  input  logic                  f2cReady_in,
  input  logic                  f2cReset_in,
  output logic [PTR_W-1:0]      curSrc_out,
  output logic                  busy_out,
  output logic                  underrun_out
`ifdef F2C_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0] chunkCount_out,
  output uint32                 underrunCount_out
`endif
);

  arbState_t        state, nextState;
  logic [PTR_W-1:0] rrPtr, curSrc, winner;
  logic [QW_W-1:0]  qwCount;
  logic             underrun, anyReq;
  logic             grant, xferQw, lastQw, underrunQw;
  uint64            srcWord [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign srcWord[i] = srcData_in[64*i +: 64];
  end

  rr_pick #(
    .NUM_SRC(NUM_SRC),
    .PTR_W  (PTR_W)
  ) u_rrPick (
    .req   (srcChunkRdy_in & srcEnable_in),
    .rrPtr (rrPtr),
    .winner(winner),
    .anyReq(anyReq)
  );

  assign grant      = (state == S_IDLE) && anyReq;
  assign xferQw     = (state == S_XFER) && f2cReady_in;
  assign lastQw     = xferQw && (qwCount == '0);
  assign underrunQw = xferQw && !srcValid_in[curSrc];

  // A flush overrides any in-progress chunk; otherwise a chunk ends only on its last QW.
  always_comb begin
    nextState    = state;
    f2cData_out  = '0;
    f2cValid_out = 1'b0;
    srcReady_out = '0;
    srcReset_out = {NUM_SRC{f2cReset_in && !pcieRst_in}};
    busy_out     = (state == S_XFER);
    curSrc_out   = curSrc;
    underrun_out = underrun;
    unique case (state)
      S_IDLE: if (anyReq) nextState = S_XFER;
      S_XFER: begin
        f2cData_out          = srcWord[curSrc];
        f2cValid_out         = srcValid_in[curSrc];
        srcReady_out[curSrc] = f2cReady_in;
        if (lastQw) nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
    if (f2cReset_in) nextState = S_IDLE;
  end

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      state    <= S_IDLE;
      rrPtr    <= '0;
      qwCount  <= '0;
      curSrc   <= '0;
      underrun <= 1'b0;
    end else begin
      state <= nextState;
      if (f2cReset_in) begin
        rrPtr   <= '0;
        qwCount <= '0;
      end else begin
        if (grant) begin
          curSrc  <= winner;
          qwCount <= QW_W'(CHUNK_QWS - 1);
          rrPtr   <= (int'(winner) == NUM_SRC - 1) ? '0 : winner + 1'b1;
        end else if (xferQw) begin
          qwCount <= qwCount - 1'b1;
        end
        if (underrunQw) underrun <= 1'b1;
      end
    end
  end

`ifdef F2C_ARB_STATS_EN
  uint32 chunkCnt [NUM_SRC];
  uint32 underrunCnt;

  // Saturating counters; a flush discards them together with the pipe contents.
  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in || f2cReset_in) begin
      for (int i = 0; i < NUM_SRC; i++) chunkCnt[i] <= '0;
      underrunCnt <= '0;
    end else begin
      if (lastQw && (chunkCnt[curSrc] != '1)) chunkCnt[curSrc] <= chunkCnt[curSrc] + 1'b1;
      if (underrunQw && (underrunCnt != '1)) underrunCnt <= underrunCnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_pack
    assign chunkCount_out[32*i +: 32] = chunkCnt[i];
  end
  assign underrunCount_out = underrunCnt;
`endif

endmodule

// File: doc/f2c_chunk_arb.md
Name: f2c_chunk_arb

Overview:
- Round-robin scheduler sharing the single FPGA->CPU DMA pipe of the TLP transmitter between NUM_SRC producer pipes.
- Grants one producer for exactly one whole chunk (CHUNK_QWS quadwords), then re-arbitrates. The transmitter always sees contiguous, complete chunks from a single source.
- Sits between the per-source F2C FIFOs and the transmitter's f2cData/f2cValid/f2cReady/f2cReset pipe.

Parameters:
- NUM_SRC, 4, number of producer pipes; 2..16.
- CHUNK_QWS, 128, quadwords per chunk; power of two, must equal the F2C chunk size in QWs.

Ports:
- pcieClk_in  in  1  125MHz PCIe core clock.
- pcieRst_in  in  1  reset, synchronous, active-high.
- srcData_in  in  NUM_SRC*64  producer data; source i in bits [64i+63:64i].
- srcValid_in  in  NUM_SRC  per-source QW valid.
- srcChunkRdy_in  in  NUM_SRC  source i holds >= CHUNK_QWS QWs.
- srcEnable_in  in  NUM_SRC  per-source arbitration enable mask.
- srcReady_out  out  NUM_SRC  per-source read commit.
- srcReset_out  out  NUM_SRC  per-source FIFO flush.
- f2cData_out  out  64  to transmitter DMA pipe.
- f2cValid_out  out  1  to transmitter.
- f2cReady_in  in  1  transmitter read commit.
- f2cReset_in  in  1  transmitter DMA-disable flush.
- curSrc_out  out  $clog2(NUM_SRC)  granted source; valid while busy_out=1.
- busy_out  out  1  chunk in progress.
- underrun_out  out  1  sticky: ready seen while granted source not valid.

Behaviour:
- Reset values: state S_IDLE, rrPtr=0, qwCount=0, busy_out=0, curSrc_out=0, underrun_out=0, f2cValid_out=0, srcReady_out=0, f2cData_out=0.
- S_IDLE:
  - Candidates: srcChunkRdy_in & srcEnable_in.
  - Pick the first candidate searching upward from rrPtr, with modulo-NUM_SRC wrap.
  - Registered grant: next cycle enter S_XFER with curSrc=winner, qwCount=CHUNK_QWS-1, rrPtr=winner+1 (mod NUM_SRC).
  - With no candidate, stay in S_IDLE.
  - Grant latency: one cycle from candidate visible to f2cValid_out.
- S_XFER, combinational pass-through with zero added latency:
  - f2cData_out = srcData_in[curSrc].
  - f2cValid_out = srcValid_in[curSrc].
  - srcReady_out[curSrc] = f2cReady_in; all other srcReady_out bits = 0.
- QW accounting:
  - Each f2cReady_in decrements qwCount.
  - f2cReady_in with qwCount==0 is the last QW: go to S_IDLE next cycle.
  - There is no idle gap beyond the one-cycle re-grant.
- Underrun: f2cReady_in=1 while srcValid_in[curSrc]=0 sets underrun_out (sticky until reset). The QW still counts, so the transmitter's framing stays intact.
- srcEnable_in deasserted mid-chunk does not abort; the current chunk completes.
- In S_IDLE: f2cValid_out=0, srcReady_out=0, f2cData_out=0. f2cReady_in in S_IDLE is ignored and does not set underrun.
- Flush (f2cReset_in=1):
  - srcReset_out = all ones in the same cycle (combinational).
  - Next state S_IDLE, rrPtr=0, qwCount=0; underrun_out is not cleared.
- Simultaneous events:
  - f2cReset_in together with the last QW: reset wins, and the chunk is not counted.
  - pcieRst_in overrides everything and also clears underrun_out.
  - pcieRst_in mid-chunk abandons the chunk; srcReset_out is 0 during pcieRst_in.
- Width: qwCount is $clog2(CHUNK_QWS) bits and wraps naturally. rrPtr increments modulo NUM_SRC and also works for non-power-of-two NUM_SRC.

Optional Feature:
- Macro F2C_ARB_STATS_EN.
- Defined:
  - Adds output chunkCount_out, NUM_SRC*32 bits: per-source count of completed chunks, saturating at 2^32-1.
  - Adds output underrunCount_out, 32 bits: count of underrun QWs, saturating.
  - Both counters clear on pcieRst_in or f2cReset_in.
- Undefined: neither port nor their registers exist; behaviour is otherwise identical.

Decomposition:
- Package tlp_xcvr_pkg:
  - arbiter state enum (S_IDLE, S_XFER);
  - CHUNK_QWS default derived from F2C_CHUNKSIZE/8;
  - uint64, uint32 (already present).
- One sub-module: rr_pick, a combinational round-robin priority selector.
  - Inputs: request vector, rrPtr.
  - Outputs: winner index, anyReq.
- FSM, counters and muxing stay in f2c_chunk_arb.

Test Plan:
- NUM_SRC=4, CHUNK_QWS=8.
  - Stimulus: sources 0 and 2 chunk-ready, f2cReady_in held high.
  - Required: src0 streams 8 QWs, a one-cycle gap, then src2 streams 8 QWs; curSrc_out sequence is 0,2; rrPtr=3 afterwards.
- All four sources continuously ready.
  - Required: grant order 0,1,2,3,0; each srcReady_out bit pulses exactly 8 times per chunk.
- f2cReady_in toggling 1/0 during a chunk.
  - Required: chunk takes 16 cycles; data order preserved; no other srcReady_out bit asserted.
- f2cReset_in asserted at QW 5 of a src1 chunk.
  - Required: srcReset_out=4'b1111 in that cycle; S_IDLE next cycle; next grant searches from src0.
- srcValid_in[curSrc] dropped for 2 cycles while f2cReady_in=1.
  - Required: underrun_out=1 and stays set; chunk still ends after 8 readies.
  - With F2C_ARB_STATS_EN: underrunCount_out=2.
- Source 3 enabled and chunk-ready, srcEnable_in[3] cleared mid-chunk.
  - Required: the chunk completes with 8 QWs and src3 is not granted again.
  - With F2C_ARB_STATS_EN: chunkCount_out for source 3 = 1.
